// File: rtl/tick_period_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tick_period_meter
//  Description : Measures the src_clk-cycle interval between rising edges of
//                a strobe, reports each period with a one-cycle valid pulse,
//                tracks min/max, flags lock against an expected ratio and
//                flags loss of the strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_period_meter #(
    parameter int W        = 32,
    parameter int EXPECT   = 1000,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 4096,
    parameter int SYNC     = 0
) (
    input  logic         src_clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         tick_in,
    input  logic         clr_minmax,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic [W-1:0] period_min,
    output logic [W-1:0] period_max,
    output logic         locked,
    output logic         timeout
);

    localparam int              MW          = $clog2(LOCK_CNT + 1);
    localparam logic [W:0]      LIM_TIMEOUT = (W+1)'(TIMEOUT);
    localparam logic [W:0]      EXP_W       = (W+1)'(EXPECT);
    localparam logic [W:0]      TOL_W       = (W+1)'(TOL);
    // Lock window bounds in W+1 bits; the lower bound clamps at zero when
    // the tolerance exceeds the target.
    localparam logic [W:0]      WIN_HI      = EXP_W + TOL_W;
    localparam logic [W:0]      WIN_LO      = (EXP_W > TOL_W) ? (EXP_W - TOL_W) : '0;
    localparam logic [MW-1:0]   LOCK_TGT    = MW'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        TOUT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [W-1:0]  cnt;
    logic [W-1:0]  cnt_n;
    logic [W:0]    cnt_inc;
    logic [MW-1:0] match;
    logic [MW-1:0] match_inc;
    logic          tick_s;
    logic          tick_q;
    logic          tick_edge;
    logic          report;
    logic          to_fire;
    logic          to_clear;
    logic          in_range;

    generate
        if (SYNC != 0) begin : g_sync
            logic [1:0] sync_ff;
            // Two-flop synchroniser for a strobe from another clock domain
            always_ff @(posedge src_clk) begin
                if (!rst_n) begin
                    sync_ff <= 2'b00;
                end else begin
                    sync_ff <= {sync_ff[0], tick_in};
                end
            end
            assign tick_s = sync_ff[1];
        end else begin : g_nosync
            assign tick_s = tick_in;
        end
    endgenerate

    assign tick_edge = tick_s & ~tick_q;
    // cnt+1 is the candidate period; kept one bit wider so the window and
    // timeout compares never wrap.
    assign cnt_inc   = {1'b0, cnt} + (W+1)'(1);
    assign in_range  = (cnt_inc >= WIN_LO) && (cnt_inc <= WIN_HI);
    assign match_inc = (match >= LOCK_TGT) ? match : match + MW'(1);

    // State register
    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, counter and event decode
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        report   = 1'b0;
        to_fire  = 1'b0;
        to_clear = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick_edge) begin
                        state_n = MEAS;
                        cnt_n   = '0;
                    end
                end
                MEAS: begin
                    if (tick_edge) begin
                        report = 1'b1;
                        cnt_n  = '0;
                    end else if (cnt_inc == LIM_TIMEOUT) begin
                        state_n = TOUT;
                        cnt_n   = '0;
                        to_fire = 1'b1;
                    end else begin
                        cnt_n = cnt_inc[W-1:0];
                    end
                end
                TOUT: begin
                    cnt_n = '0;
                    if (tick_edge) begin
                        state_n  = MEAS;
                        to_clear = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Counter, edge history, period report, trackers, lock and timeout flags
    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            tick_q       <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            period_min   <= '1;
            period_max   <= '0;
            match        <= '0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            cnt          <= cnt_n;
            // Tracks even while disabled so a level already high at enable
            // is not mistaken for a fresh edge.
            tick_q       <= tick_s;
            period_valid <= report;
            if (report) begin
                period <= cnt_inc[W-1:0];
            end

            if (report) begin
                if (clr_minmax) begin
                    period_min <= cnt_inc[W-1:0];
                    period_max <= cnt_inc[W-1:0];
                end else begin
                    if (cnt_inc[W-1:0] < period_min) period_min <= cnt_inc[W-1:0];
                    if (cnt_inc[W-1:0] > period_max) period_max <= cnt_inc[W-1:0];
                end
            end else if (clr_minmax) begin
                period_min <= '1;
                period_max <= '0;
            end

            if (!en || to_fire) begin
                match  <= '0;
                locked <= 1'b0;
            end else if (report) begin
                if (in_range) begin
                    match <= match_inc;
                    if (match_inc >= LOCK_TGT) locked <= 1'b1;
                end else begin
                    match  <= '0;
                    locked <= 1'b0;
                end
            end

            if (!en) begin
                timeout <= 1'b0;
            end else if (to_fire) begin
                timeout <= 1'b1;
            end else if (to_clear) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_period_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_tick_period_meter
//  Description : Scoreboard bench for tick_period_meter; one unsynchronised
//                and one synchronised instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_period_meter;

    localparam int W        = 16;
    localparam int EXPECT   = 10;
    localparam int TOL      = 2;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 64;
    localparam int ONES     = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, en_s, tick_in, clr_minmax, clr_s;
    logic [W-1:0] period0, min0, max0, period1, min1, max1;
    logic valid0, locked0, timeout0, valid1, locked1, timeout1;

    tick_period_meter #(.W(W), .EXPECT(EXPECT), .TOL(TOL), .LOCK_CNT(LOCK_CNT),
                        .TIMEOUT(TIMEOUT), .SYNC(0)) dut (
        .src_clk(clk), .rst_n(rst_n), .en(en), .tick_in(tick_in), .clr_minmax(clr_minmax),
        .period(period0), .period_valid(valid0), .period_min(min0), .period_max(max0),
        .locked(locked0), .timeout(timeout0));

    tick_period_meter #(.W(W), .EXPECT(EXPECT), .TOL(TOL), .LOCK_CNT(LOCK_CNT),
                        .TIMEOUT(TIMEOUT), .SYNC(1)) dut_s (
        .src_clk(clk), .rst_n(rst_n), .en(en_s), .tick_in(tick_in), .clr_minmax(clr_s),
        .period(period1), .period_valid(valid1), .period_min(min1), .period_max(max1),
        .locked(locked1), .timeout(timeout1));

    typedef struct {
        int p;
        int mn;
        int mx;
        int lk;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state
    logic nxt_rst, nxt_en, nxt_en_s;
    logic [1:0] clr_hist;
    logic m_prev;
    int m_open, m_since, m_min, m_max, m_match, m_locked;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid0 === 1'b1) begin
            vectors++;
            if (q0.size() == 0) begin
                miscompares++;
                $display("FAIL sb0_unexpected: period_valid with period=%0d at cyc %0d, required no report", period0, cyc);
            end else begin
                e0 = q0.pop_front();
                if (period0 !== e0.p || min0 !== e0.mn || max0 !== e0.mx || locked0 !== e0.lk[0] || cyc !== e0.cyc) begin
                    miscompares++;
                    $display("FAIL sb0_report: got p=%0d min=%0d max=%0d lk=%b cyc=%0d, required p=%0d min=%0d max=%0d lk=%0d cyc=%0d",
                             period0, min0, max0, locked0, cyc, e0.p, e0.mn, e0.mx, e0.lk, e0.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (valid1 === 1'b1) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL sb1_unexpected: period_valid with period=%0d at cyc %0d, required no report", period1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (period1 !== e1.p || min1 !== e1.mn || max1 !== e1.mx || locked1 !== e1.lk[0] || cyc !== e1.cyc) begin
                    miscompares++;
                    $display("FAIL sb1_report: got p=%0d min=%0d max=%0d lk=%b cyc=%0d, required p=%0d min=%0d max=%0d lk=%0d cyc=%0d",
                             period1, min1, max1, locked1, cyc, e1.p, e1.mn, e1.mx, e1.lk, e1.cyc);
                end
            end
        end
    end

    task automatic model_reset();
        m_open = 0; m_since = 0; m_min = ONES; m_max = 0;
        m_match = 0; m_locked = 0; m_prev = 1'b0;
    endtask

    task automatic model_report(input int p, input logic clr);
        exp_t e;
        if (clr) begin
            m_min = p; m_max = p;
        end else begin
            if (p < m_min) m_min = p;
            if (p > m_max) m_max = p;
        end
        if (p >= EXPECT - TOL && p <= EXPECT + TOL) begin
            if (m_match < LOCK_CNT) m_match++;
            if (m_match >= LOCK_CNT) m_locked = 1;
        end else begin
            m_match = 0; m_locked = 0;
        end
        e.p = p; e.mn = m_min; e.mx = m_max; e.lk = m_locked;
        e.cyc = cyc + 1;
        q0.push_back(e);
        if (en_s) begin
            e.cyc = cyc + 3;
            q1.push_back(e);
        end
    endtask

    // One clock cycle of stimulus, applied just after the rising edge
    task automatic drive_cycle(input logic v, input logic clr);
        logic edge_m;
        @(posedge clk);
        #1;
        rst_n = nxt_rst; en = nxt_en; en_s = nxt_en_s;
        tick_in = v; clr_minmax = clr;
        clr_s = clr_hist[1];
        clr_hist = {clr_hist[0], clr};
        if (!nxt_rst) begin
            model_reset();
        end else begin
            edge_m = v && !m_prev;
            m_prev = v;
            if (!nxt_en) begin
                m_open = 0; m_since = 0; m_match = 0; m_locked = 0;
                if (clr) begin m_min = ONES; m_max = 0; end
            end else begin
                m_since++;
                if (edge_m) begin
                    if (m_open != 0) model_report(m_since, clr);
                    else if (clr) begin m_min = ONES; m_max = 0; end
                    m_open = 1; m_since = 0;
                end else begin
                    if (clr) begin m_min = ONES; m_max = 0; end
                    if (m_open != 0 && m_since == TIMEOUT) begin
                        m_open = 0; m_match = 0; m_locked = 0;
                    end
                end
            end
        end
    endtask

    task automatic strobe(input int p);
        drive_cycle(1'b1, 1'b0);
        for (int i = 1; i < p; i++) drive_cycle(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        nxt_rst = 1'b0;
        repeat (3) drive_cycle(1'b0, 1'b0);
        vectors++;
        if (period0 !== 0 || valid0 !== 0 || min0 !== ONES || max0 !== 0 || locked0 !== 0 || timeout0 !== 0) begin
            miscompares++;
            $display("FAIL reset0: got p=%0d v=%b min=%0d max=%0d lk=%b to=%b, required 0 0 %0d 0 0 0",
                     period0, valid0, min0, max0, locked0, timeout0, ONES);
        end
        vectors++;
        if (period1 !== 0 || valid1 !== 0 || min1 !== ONES || max1 !== 0 || locked1 !== 0 || timeout1 !== 0) begin
            miscompares++;
            $display("FAIL reset1: got p=%0d v=%b min=%0d max=%0d lk=%b to=%b, required 0 0 %0d 0 0 0",
                     period1, valid1, min1, max1, locked1, timeout1, ONES);
        end
        nxt_rst = 1'b1; nxt_en = 1'b1;
        repeat (2) drive_cycle(1'b0, 1'b0);
    endtask

    task automatic test_lock();
        repeat (7) strobe(10);
        vectors++;
        if (locked0 !== 1'b1 || period0 !== 10) begin
            miscompares++;
            $display("FAIL lock: got locked=%b period=%0d, required locked=1 period=10", locked0, period0);
        end
    endtask

    task automatic test_deviation();
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0);
        vectors++;
        if (min0 !== ONES || max0 !== 0) begin
            miscompares++;
            $display("FAIL clr_alone: got min=%0d max=%0d, required min=%0d max=0", min0, max0, ONES);
        end
        repeat (7) drive_cycle(1'b0, 1'b0);
        strobe(10); strobe(13); strobe(10); strobe(10);
        vectors++;
        if (locked0 !== 1'b0 || min0 !== 10 || max0 !== 13) begin
            miscompares++;
            $display("FAIL deviation: got locked=%b min=%0d max=%0d, required locked=0 min=10 max=13", locked0, min0, max0);
        end
    endtask

    task automatic test_timeout();
        repeat (3) strobe(10);
        drive_cycle(1'b1, 1'b0);
        for (int j = 1; j <= TIMEOUT; j++) drive_cycle(1'b0, 1'b0);
        vectors++;
        if (timeout0 !== 1'b0 || locked0 !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_edge: got timeout=%b locked=%b, required timeout=0 locked=1", timeout0, locked0);
        end
        drive_cycle(1'b0, 1'b0);
        vectors++;
        if (timeout0 !== 1'b1 || locked0 !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_fire: got timeout=%b locked=%b, required timeout=1 locked=0", timeout0, locked0);
        end
        repeat (5) drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0);
        vectors++;
        if (timeout0 !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: got timeout=%b, required 0", timeout0);
        end
        repeat (8) drive_cycle(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 1'b0);
        repeat (7) drive_cycle(1'b0, 1'b0);
        nxt_rst = 1'b0;
        drive_cycle(1'b0, 1'b0);
        nxt_rst = 1'b1;
        drive_cycle(1'b0, 1'b0);
        vectors++;
        if (period0 !== 0 || valid0 !== 0 || min0 !== ONES || max0 !== 0 || locked0 !== 0 || timeout0 !== 0) begin
            miscompares++;
            $display("FAIL reset_mid: got p=%0d v=%b min=%0d max=%0d lk=%b to=%b, required 0 0 %0d 0 0 0",
                     period0, valid0, min0, max0, locked0, timeout0, ONES);
        end
        repeat (3) strobe(10);
    endtask

    task automatic test_enable();
        repeat (2) strobe(10);
        nxt_en = 1'b0;
        repeat (2) strobe(10);
        vectors++;
        if (locked0 !== 1'b0 || timeout0 !== 1'b0 || period0 !== 10) begin
            miscompares++;
            $display("FAIL enable_low: got locked=%b timeout=%b period=%0d, required 0 0 10", locked0, timeout0, period0);
        end
        nxt_en = 1'b1;
        repeat (3) strobe(10);
    endtask

    task automatic test_sync();
        nxt_rst = 1'b0;
        drive_cycle(1'b0, 1'b0);
        nxt_rst = 1'b1; nxt_en = 1'b1; nxt_en_s = 1'b1;
        repeat (3) drive_cycle(1'b0, 1'b0);
        repeat (3) strobe(10);
        strobe(12);
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b0, 1'b0);
        vectors++;
        if (min0 !== 12 || max0 !== 12) begin
            miscompares++;
            $display("FAIL clr_update0: got min=%0d max=%0d, required 12 12", min0, max0);
        end
        repeat (2) drive_cycle(1'b0, 1'b0);
        vectors++;
        if (min1 !== 12 || max1 !== 12) begin
            miscompares++;
            $display("FAIL clr_update1: got min=%0d max=%0d, required 12 12", min1, max1);
        end
        repeat (6) drive_cycle(1'b0, 1'b0);
        repeat (3) strobe(10);
        nxt_en_s = 1'b0;
        repeat (2) drive_cycle(1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; en_s = 1'b0; tick_in = 1'b0;
        clr_minmax = 1'b0; clr_s = 1'b0; clr_hist = 2'b00;
        nxt_rst = 1'b0; nxt_en = 1'b0; nxt_en_s = 1'b0;
        model_reset();
        test_reset();
        test_lock();
        test_deviation();
        test_timeout();
        test_reset_mid();
        test_enable();
        test_sync();
        nxt_en = 1'b0;
        repeat (5) drive_cycle(1'b0, 1'b0);
        vectors++;
        if (q0.size() != 0) begin
            miscompares++;
            $display("FAIL sb0_drain: got %0d reports outstanding, required 0", q0.size());
        end
        vectors++;
        if (q1.size() != 0) begin
            miscompares++;
            $display("FAIL sb1_drain: got %0d reports outstanding, required 0", q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
